vdp_vblank_write_scheduler: RTL
===============================

Name: vdp_vblank_write_scheduler

Overview:
- Sequences CPU writes into the VDP configuration/colour registers so that they land only during vertical blanking, which prevents tearing in the visible frame.
- Sits between the AHB-facing VDP slave logic (the requester) and the VDP register file (the datapath).
- Queues deferred writes in a FIFO and drains it during vblank, up to a per-frame write budget.
- Provides an immediate path for writes that must bypass deferral.

Parameters:
- ADDR_W, 4: VDP register address width.
- DATA_W, 32: register data width.
- DEPTH, 8: FIFO entries; must be a power of 2 and at least 2.
- BUDGET, 16: maximum deferred writes issued per vblank period; must be at least 1.
- CNT_W, $clog2(DEPTH+1): derived; width of the occupancy count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- vblank  in  1  level; high while the sync generator is outside the vertical display region.
- flush  in  1  synchronous FIFO clear.
- req_valid  in  1  write request.
- req_immediate  in  1  1 = bypass deferral; qualified by req_valid.
- req_addr  in  ADDR_W  register address.
- req_data  in  DATA_W  register data.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- reg_we  out  1  register-file write strobe.
- reg_addr  out  ADDR_W  write address.
- reg_data  out  DATA_W  write data.
- pending  out  CNT_W  FIFO occupancy.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clk. All state is on posedge clk.
- Reset values: reg_we=0, reg_addr=0, reg_data=0, pending=0, busy=0, FIFO empty, state=IDLE, vblank_d=0, budget counter=0. req_ready is combinational and equals 1 after reset while the FIFO is empty.
- Vblank edge detection: vblank_rise = vblank & ~vblank_d.
  - On vblank_rise the budget counter loads BUDGET.
  - Because vblank_d resets to 0, vblank high at reset release counts as a rise.
- Pop condition (combinational): drain_go = vblank & FIFO non-empty & (budget>0 | vblank_rise) & ~flush.
- Issue:
  - When drain_go: pop the head entry; reg_we=1 next cycle with that entry's addr/data.
  - Budget decrements per pop, saturating at 0. On the vblank_rise cycle the counter loads BUDGET-1 if drain_go, otherwise BUDGET.
- req_ready:
  - Deferred request (req_immediate=0): ready = ~full & ~flush.
  - Immediate request: ready = FIFO empty & ~drain_go & ~flush. This preserves ordering: an immediate write never overtakes queued writes.
- Immediate write accepted at cycle t: reg_we=1 at t+1 with req_addr/req_data.
- Deferred write accepted at cycle t: pushed at t and visible in pending at t+1. Earliest pop is t+1, so earliest reg_we is t+2.
- Output registers: reg_we is deasserted in every cycle with no issue; reg_addr/reg_data hold their last values.
- Push and pop in the same cycle: both happen and pending is unchanged. Push is blocked only when full (no pop-through).
- flush:
  - Clears the FIFO pointers and pending at the next edge.
  - Forces req_ready=0 and blocks pop in that cycle.
  - An issue already registered from the previous cycle still appears on reg_we.
- FIFO pointers: log2(DEPTH) bits, wrapping naturally; full/empty derived from the count.
- State machine, updated each edge from the next-cycle conditions:
  - IDLE: FIFO empty. Goes to ARMED on push.
  - ARMED: entries present, vblank low. Goes to DRAIN on vblank high with budget available.
  - DRAIN: popping one entry per cycle.
    - Goes to IDLE when the FIFO becomes empty.
    - Goes to EXHAUSTED when budget reaches 0 with entries left and vblank still high.
    - Goes to ARMED when vblank falls with entries left.
  - EXHAUSTED: waits for vblank low, then goes to ARMED.
  - Any state goes to IDLE on flush when no push occurs that cycle.
  - busy = (state != IDLE).
- Mid-drain vblank fall: the current-cycle pop requires vblank=1, so no pop occurs after the falling edge. Residual entries wait for the next vblank_rise.
- Reset mid-operation: the FIFO contents are discarded and all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Shared package vdp_pkg:
  - State encoding localparams: IDLE=0, ARMED=1, DRAIN=2, EXHAUSTED=3.
  - ADDR_W/DATA_W defaults, shared with the VDP register file.
- One sub-module: vdp_sync_fifo.
  - Parameterised by DEPTH and width ADDR_W+DATA_W.
  - Ports: push, pop, clear, dout, full, empty, count.
- The scheduler FSM, budget counter and output registers stay in the top module.

Test Plan:
1. vblank=0; push 3 deferred writes (A1..A3, D=0x11,0x22,0x33) -> no reg_we, pending=3, busy=1. Raise vblank -> reg_we on 3 consecutive cycles starting 1 cycle after the rise, in order A1..A3, then pending=0 and state IDLE.
2. BUDGET=16; queue 8 entries (DEPTH=8, full, req_ready=0) across two vblanks with budget forced to 5 via a parameter override BUDGET=5 -> 5 writes in the first vblank, state EXHAUSTED, then 3 writes after the next vblank rise.
3. FIFO empty; immediate write addr 0x2, data 0xDEADBEEF at cycle t -> reg_we=1 at t+1 with matching addr/data. Repeat with 1 entry queued -> req_ready=0 until the FIFO drains.
4. vblank drops after 2 of 4 pops -> exactly 2 reg_we pulses, state ARMED, pending=2. Remaining 2 issue after the next rise.
5. FIFO full and vblank high: simultaneous push and pop -> push blocked (req_ready=0), pop proceeds. Next cycle req_ready=1 and a push+pop keeps pending at 7.
6. flush with 5 pending, then reset asserted mid-drain -> pending=0 after flush with no further reg_we; on reset, reg_we/reg_addr/reg_data/pending/busy return to 0 asynchronously.

Source files
------------

// File: rtl/vdp_pkg.sv
// vdp_pkg
// Shared definitions for the VDP register-write path: default register
// address/data widths (also used by the VDP register file) and the state
// encoding of the vblank write scheduler.
package vdp_pkg;

   localparam int VDP_ADDR_W = 4;
   localparam int VDP_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMED     = 2'd1,
      DRAIN     = 2'd2,
      EXHAUSTED = 2'd3
   } sched_state_e;

endpackage

// File: rtl/vdp_sync_fifo.sv
// vdp_sync_fifo
// Single-clock FIFO holding deferred register writes.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push, din    write an entry (ignored when full)
//   pop          discard the head entry (ignored when empty)
//   clear        synchronous flush of all entries, wins over push/pop
//   dout         head entry, valid whenever empty is low
//   full, empty  derived from the occupancy count
//   count        number of entries held
module vdp_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 36,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
   // pointers simply wrap; full/empty come from the count, which removes
   // the usual pointer-equality ambiguity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array has no reset; resetting the pointers is enough to
   // discard its contents.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vdp_vblank_write_scheduler.sv
// vdp_vblank_write_scheduler
// Defers CPU writes to the VDP register file until vertical blanking so
// the visible frame never tears. Deferred writes are queued and drained
// during vblank, at most BUDGET per vblank period; immediate writes go
// straight through, but only when nothing is queued so order is kept.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   vblank                          level, high outside the display region
//   flush                           synchronous queue clear
//   req_valid/req_immediate/
//   req_addr/req_data/req_ready     write request handshake
//   reg_we/reg_addr/reg_data        registered write to the register file
//   pending                         queue occupancy
//   busy                            scheduler not idle
module vdp_vblank_write_scheduler
   import vdp_pkg::*;
#(
   parameter int ADDR_W = VDP_ADDR_W,
   parameter int DATA_W = VDP_DATA_W,
   parameter int DEPTH  = 8,
   parameter int BUDGET = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vblank,
   input  logic              flush,
   input  logic              req_valid,
   input  logic              req_immediate,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              req_ready,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_data,
   output logic [CNT_W-1:0]  pending,
   output logic              busy
);

   localparam int BUD_W = $clog2(BUDGET + 1);

   sched_state_e               state;
   sched_state_e               state_next;
   logic                       vblank_d;
   logic                       vblank_rise;
   logic [BUD_W-1:0]           budget;
   logic [BUD_W-1:0]           budget_next;
   logic                       drain_go;
   logic                       push;
   logic                       imm_fire;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [CNT_W-1:0]           fifo_count;
   logic [CNT_W-1:0]           count_next;
   logic [ADDR_W+DATA_W-1:0]   fifo_dout;

   assign vblank_rise = vblank & ~vblank_d;
   assign drain_go    = vblank & ~fifo_empty & ((budget != '0) | vblank_rise) & ~flush;
   assign push        = req_valid & ~req_immediate & req_ready;
   assign imm_fire    = req_valid & req_immediate & req_ready;
   assign pending     = fifo_count;
   assign busy        = (state != IDLE);

   // An immediate write is only allowed once the queue is empty and not
   // being drained, so it can never overtake a deferred write.
   always_comb begin
      req_ready = 1'b0;
      if (!flush) begin
         if (req_immediate) req_ready = fifo_empty & ~drain_go;
         else               req_ready = ~fifo_full;
      end
   end

   // Budget refills on each vblank rise; a pop on that same cycle is
   // charged against the fresh budget.
   always_comb begin
      budget_next = budget;
      if (vblank_rise)
         budget_next = drain_go ? BUD_W'(BUDGET - 1) : BUD_W'(BUDGET);
      else if (drain_go && budget != '0)
         budget_next = budget - 1'b1;
   end

   // Occupancy after this edge, used to pick the next state.
   always_comb begin
      count_next = fifo_count;
      if (flush)                  count_next = '0;
      else if (push && !drain_go) count_next = fifo_count + 1'b1;
      else if (drain_go && !push) count_next = fifo_count - 1'b1;
   end

   // Next state follows what the queue and vblank will look like after
   // the edge: empty means IDLE, outside vblank entries wait in ARMED,
   // inside vblank they drain until the budget runs out.
   always_comb begin
      state_next = IDLE;
      if (count_next == '0)        state_next = IDLE;
      else if (!vblank)            state_next = ARMED;
      else if (budget_next == '0)  state_next = EXHAUSTED;
      else                         state_next = DRAIN;
   end

   // Scheduler registers and the registered write port. Address/data hold
   // their last value when no write is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         vblank_d <= 1'b0;
         budget   <= '0;
         reg_we   <= 1'b0;
         reg_addr <= '0;
         reg_data <= '0;
      end else begin
         state    <= state_next;
         vblank_d <= vblank;
         budget   <= budget_next;
         reg_we   <= drain_go | imm_fire;
         if (drain_go) begin
            reg_addr <= fifo_dout[ADDR_W+DATA_W-1:DATA_W];
            reg_data <= fifo_dout[DATA_W-1:0];
         end else if (imm_fire) begin
            reg_addr <= req_addr;
            reg_data <= req_data;
         end
      end
   end

   vdp_sync_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(ADDR_W + DATA_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (drain_go),
      .clear (flush),
      .din   ({req_addr, req_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule
